ucie_ctl_tx_flit_framer: RTL

Downstream stage of the controller TX path. It consumes the 64-bit words drained from the TX FIFO under the lp_valid/lp_irdy/pl_trdy handshake and frames them into flits for the RDI/PHY side. Each flit is a header word (marker plus sequence number), WORDS_PER_FLIT payload words and an optional XOR checksum trailer. Flow control is a single-register output stage with backpressure from the PHY.

---
 rtl/ucie_ctl_tx_flit_framer.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/ucie_ctl_tx_flit_framer.sv
// TX flit framer: wraps upstream words into header/payload(/checksum trailer) flits
// behind a single-register PHY output slot. Trailer enabled by UCIE_CTL_TX_FLIT_CRC_EN.
module ucie_ctl_tx_flit_framer #(
    parameter int DATA_W         = 64,
    parameter int WORDS_PER_FLIT = 4,
    parameter int SEQ_W          = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [3:0]        i_state_sts,
    input  logic              i_lp_valid,
    input  logic              i_lp_irdy,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_lp_trdy,
    output logic              o_phy_valid,
    output logic [DATA_W-1:0] o_phy_data,
    output logic              o_phy_sof,
    output logic              o_phy_eof,
    input  logic              i_phy_trdy,
    output logic [SEQ_W-1:0]  o_seq_num,
    output logic              o_flit_done
);

    localparam int         CNT_W      = (WORDS_PER_FLIT > 1) ? $clog2(WORDS_PER_FLIT) : 1;
    localparam logic [7:0] HDR_MARKER = 8'hA5;

`ifdef UCIE_CTL_TX_FLIT_CRC_EN
    typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAYLOAD, S_TRL} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAYLOAD} state_t;
`endif

    state_t              r_state, w_state_next;
    logic [CNT_W-1:0]    r_cnt, w_cnt_next;
    logic [SEQ_W-1:0]    r_seq;
    logic                r_valid, r_sof, r_eof, r_flit_done;
    logic [DATA_W-1:0]   r_data;

    logic                w_active, w_slot_free, w_last, w_lp_trdy;
    logic                w_load, w_load_sof, w_load_eof;
    logic [DATA_W-1:0]   w_load_data, w_header;

`ifdef UCIE_CTL_TX_FLIT_CRC_EN
    logic [DATA_W-1:0]   r_csum, w_csum_next;
`endif

    assign w_active    = (i_state_sts == 4'b0001);
    assign w_slot_free = !r_valid || i_phy_trdy;
    assign w_last      = (r_cnt == CNT_W'(WORDS_PER_FLIT - 1));

    // Header layout, MSB first: marker, sequence number, zero fill.
    always_comb begin
        w_header                       = '0;
        w_header[DATA_W-1 -: 8]        = HDR_MARKER;
        w_header[DATA_W-9 -: SEQ_W]    = r_seq;
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_lp_trdy    = 1'b0;
        w_load       = 1'b0;
        w_load_sof   = 1'b0;
        w_load_eof   = 1'b0;
        w_load_data  = '0;
`ifdef UCIE_CTL_TX_FLIT_CRC_EN
        w_csum_next  = r_csum;
`endif
        case (r_state)
            S_IDLE: begin
                // The request word only triggers the header; it is consumed in PAYLOAD.
                if (w_active && i_lp_valid && i_lp_irdy) begin
                    w_state_next = S_HDR;
                end
            end
            S_HDR: begin
                if (w_active && w_slot_free) begin
                    w_load       = 1'b1;
                    w_load_sof   = 1'b1;
                    w_load_data  = w_header;
                    w_cnt_next   = '0;
`ifdef UCIE_CTL_TX_FLIT_CRC_EN
                    w_csum_next  = '0;
`endif
                    w_state_next = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                w_lp_trdy = w_active && w_slot_free;
                if (w_lp_trdy && i_lp_valid && i_lp_irdy) begin
                    w_load      = 1'b1;
                    w_load_data = i_data;
`ifdef UCIE_CTL_TX_FLIT_CRC_EN
                    w_csum_next = r_csum ^ i_data;
`endif
                    if (w_last) begin
                        w_cnt_next   = '0;
`ifdef UCIE_CTL_TX_FLIT_CRC_EN
                        w_state_next = S_TRL;
`else
                        w_load_eof   = 1'b1;
                        w_state_next = S_IDLE;
`endif
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
            end
`ifdef UCIE_CTL_TX_FLIT_CRC_EN
            S_TRL: begin
                // Folding the header in makes the trailer cover the sequence number too.
                if (w_active && w_slot_free) begin
                    w_load       = 1'b1;
                    w_load_eof   = 1'b1;
                    w_load_data  = r_csum ^ w_header;
                    w_state_next = S_IDLE;
                end
            end
`endif
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_seq       <= '0;
            r_valid     <= 1'b0;
            r_data      <= '0;
            r_sof       <= 1'b0;
            r_eof       <= 1'b0;
            r_flit_done <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_flit_done <= r_valid && r_eof && i_phy_trdy;
            if (w_load && w_load_eof) begin
                r_seq <= r_seq + 1'b1;
            end
            if (w_load) begin
                r_valid <= 1'b1;
                r_data  <= w_load_data;
                r_sof   <= w_load_sof;
                r_eof   <= w_load_eof;
            end else if (i_phy_trdy) begin
                r_valid <= 1'b0;
                r_sof   <= 1'b0;
                r_eof   <= 1'b0;
            end
        end
    end

`ifdef UCIE_CTL_TX_FLIT_CRC_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_csum <= '0;
        end else begin
            r_csum <= w_csum_next;
        end
    end
`endif

    assign o_lp_trdy   = w_lp_trdy;
    assign o_phy_valid = r_valid;
    assign o_phy_data  = r_data;
    assign o_phy_sof   = r_sof;
    assign o_phy_eof   = r_eof;
    assign o_seq_num   = r_seq;
    assign o_flit_done = r_flit_done;

endmodule
